fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Read-side drain engine for the async FIFO, clocked entirely in the read domain.
- Pops words through the FIFO read port (rinc/rempty/rdata) and re-times them into a registered valid/ready stream through a 2-entry output buffer.
- Tags every BURST-th word with m_last and counts completed frames.
- Sits between the FIFO read port and any read-domain consumer, so downstream backpressure never reaches rinc combinationally.

Parameters:
- DSIZE, 8, data width; must match the FIFO data width.
- BURST, 4, words per frame; m_last is set on every BURST-th word; legal range 1..256.
- FCW, 16, width of the frame counter.

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  synchronous reset, active-high.
- en  input  1  drain enable; 0 stops new pops, buffered words still drain.
- rempty  input  1  FIFO empty flag (registered in rclk domain).
- rdata  input  DSIZE  FIFO read data; first-word-fall-through, valid whenever rempty=0.
- rinc  output  1  FIFO pop strobe.
- m_data  output  DSIZE  stream data (head entry).
- m_valid  output  1  stream valid.
- m_last  output  1  last word of frame; qualified by m_valid.
- m_ready  input  1  consumer accept.
- frame_cnt  output  FCW  number of frames accepted downstream.

Behaviour:
- All state is updated on the rising edge of rclk. Synchronous reset, active-high.
- Reset state (applies on the cycle after an rrst edge):
  - occupancy occ=0, m_valid=0, m_data=0, m_last=0.
  - beat counter=0, frame_cnt=0.
  - rinc=0 during rrst (gated combinationally by !rrst).
- Pop rule: rinc = !rrst & en & !rempty & (occ<2).
  - rinc does not depend on m_ready.
  - rinc is never asserted while rempty=1, so the FIFO cannot underflow.
- Pop latency: a word captured at edge k, when occ was 0 or became 0 that cycle, drives m_valid=1 with that word from cycle k+1.
- Accept: a transfer occurs on a cycle where m_valid & m_ready are both high.
- Buffer: 2 entries, head and tail, each holding {last, data}. Head drives m_data/m_last. m_valid = (occ!=0).
- Per-cycle update, by occupancy and pop/accept:
  - occ0 + pop: head <= new, occ=1.
  - occ1 + pop, no accept: tail <= new, occ=2.
  - occ1 + pop + accept: head <= new, occ stays 1. This gives full throughput of 1 word per cycle.
  - occ1 + accept, no pop: occ=0. Head contents are don't-care but are held.
  - occ2 + accept: head <= tail, occ=1. No pop that cycle, since occ<2 is false.
  - occ2, no accept: hold everything; m_data/m_last stay stable while m_valid=1.
- Last tagging:
  - The beat counter is clog2(BURST) bits, minimum 1 bit, and advances on each pop.
  - Tag last = (beat==BURST-1). The beat counter wraps to 0 on a last pop.
  - With BURST=1, every word is last.
- Frame count: frame_cnt increments by 1 on each accept with m_last=1, wrapping modulo 2^FCW.
- en deassert: pops stop in the same cycle. The beat counter holds, so a frame may span an en gap.
- Reset mid-operation: buffered words are discarded and the beat counter returns to 0. The FIFO contents are untouched. The next popped word starts a new frame.
- Stability: once m_valid=1, m_data/m_last must not change until accepted.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - entry typedef {last, data[DSIZE-1:0]};
  - localparam BCW = max(1, clog2(BURST));
  - occupancy encoding constants OCC0/OCC1/OCC2.
- One natural sub-module, stream_skid2: the 2-entry buffer with push/pop, occ output and a space flag.
- The top level contains the pop rule, beat counter and frame counter.

Test Plan:
- Reset then idle (rempty=1, en=1) -> rinc=0 and m_valid=0 indefinitely; frame_cnt=0.
- FIFO preloaded 0x01..0x08, m_ready=1 -> rinc high 8 consecutive cycles; m_data 0x01..0x08 on 8 consecutive cycles starting 1 cycle after the first rinc; m_last on 0x04 and 0x08; frame_cnt=2.
- Same preload, m_ready=0 -> exactly 2 pops (0x01, 0x02), then rinc=0. Raise m_ready -> 0x01..0x08 delivered in order with none lost or duplicated.
- m_ready toggling 1010, 8 words -> in-order delivery; m_data stable whenever m_valid=1 & m_ready=0; rinc=0 whenever occ=2.
- en dropped after 3 pops, restored 5 cycles later -> no rinc while en=0; the 4th word still carries m_last; frame_cnt=1 after 4 accepts.
- rrst asserted with occ=2 mid-frame -> next cycle m_valid=0 and frame_cnt=0; the next popped word is beat 0, so m_last arrives on the 4th word after reset.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

   localparam int DSIZE_DEF = 8;
   localparam int BURST_DEF = 4;

   localparam logic [1:0] OCC0 = 2'd0;
   localparam logic [1:0] OCC1 = 2'd1;
   localparam logic [1:0] OCC2 = 2'd2;

   // Beat counter width; a single-word frame still needs one bit.
   function automatic int calc_bcw(input int burst);
      return (burst > 1) ? $clog2(burst) : 1;
   endfunction

   localparam int BCW = calc_bcw(BURST_DEF);

   typedef struct packed {
      logic                 last;
      logic [DSIZE_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry output buffer: head drives the stream, tail absorbs one word of backpressure.
module stream_skid2
   import fifo_rd_pkg::*;
#(
   parameter int W = $bits(entry_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         ready,
   output logic [W-1:0] head,
   output logic [1:0]   occ,
   output logic         space
);

   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic [1:0]   occ_q;
   logic         accept;

   assign accept = (occ_q != OCC0) & ready;
   assign head   = head_q;
   assign occ    = occ_q;
   assign space  = (occ_q < OCC2);

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q  <= OCC0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (occ_q)
            OCC0: begin
               if (push) begin
                  head_q <= push_data;
                  occ_q  <= OCC1;
               end
            end
            OCC1: begin
               // Pop and accept together keep one word in flight at full rate.
               if (push && accept) begin
                  head_q <= push_data;
               end else if (push) begin
                  tail_q <= push_data;
                  occ_q  <= OCC2;
               end else if (accept) begin
                  occ_q  <= OCC0;
               end
            end
            OCC2: begin
               if (accept) begin
                  head_q <= tail_q;
                  occ_q  <= OCC1;
               end
            end
            default: occ_q <= OCC0;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the FIFO into a registered valid/ready stream,
// tags every BURST-th word as last and counts accepted frames.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int BURST = 4,
   parameter int FCW   = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             en,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic [FCW-1:0]   frame_cnt
);

   localparam int BCW_L = calc_bcw(BURST);

   typedef struct packed {
      logic             last;
      logic [DSIZE-1:0] data;
   } ent_t;

   logic [BCW_L-1:0] beat;
   logic             beat_last;
   logic [1:0]       occ;
   logic             space;
   ent_t             push_ent;
   ent_t             head_ent;

   assign beat_last = (beat == BCW_L'(BURST - 1));

   // Pop only on buffer space, never on m_ready, so backpressure stays registered.
   assign rinc = !rrst & en & !rempty & space;

   assign push_ent = '{last: beat_last, data: rdata};

   stream_skid2 #(
      .W($bits(ent_t))
   ) u_skid (
      .clk       (rclk),
      .rst       (rrst),
      .push      (rinc),
      .push_data (push_ent),
      .ready     (m_ready),
      .head      (head_ent),
      .occ       (occ),
      .space     (space)
   );

   assign m_valid = (occ != OCC0);
   assign m_data  = head_ent.data;
   assign m_last  = head_ent.last;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         beat <= '0;
      end else if (rinc) begin
         beat <= beat_last ? '0 : beat + 1'b1;
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         frame_cnt <= '0;
      end else if (m_valid && m_ready && m_last) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule
